alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU control decode.
- Merges ALUOp/FuncCode decode with a registered execute stage of width DATA_W in the EX stage of the pipeline.
- Adds shifts, xor/nor, an iterative signed/unsigned multiplier with HI/LO registers, and an in_valid/in_ready handshake that stalls the pipeline while a multiply runs.

---
 rtl/alu_ctl_pkg.sv | 81 ++++++++
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/iter_multiplier.sv | 62 ++++++
 rtl/alu_exec_unit.sv | 158 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctl_pkg.sv
// Shared ALU control encodings: ALUCtl codes, R-type funct values, ALUOp classes,
// execute-stage FSM states and the ALUOp/funct decode function.
package alu_ctl_pkg;

    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_XOR     = 4'b0011;
    localparam logic [3:0] CTL_MULTU   = 4'b0100;
    localparam logic [3:0] CTL_SLTU    = 4'b0101;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SLT     = 4'b0111;
    localparam logic [3:0] CTL_SLL     = 4'b1000;
    localparam logic [3:0] CTL_SRL     = 4'b1001;
    localparam logic [3:0] CTL_SRA     = 4'b1010;
    localparam logic [3:0] CTL_MULT    = 4'b1011;
    localparam logic [3:0] CTL_NOR     = 4'b1100;
    localparam logic [3:0] CTL_MFHI    = 4'b1101;
    localparam logic [3:0] CTL_MFLO    = 4'b1110;
    localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ALUOp 00 and x1 override the funct field; only ALUOp 10 looks at funct.
    function automatic logic [3:0] decode_ctl(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] ctl;
        ctl = CTL_ILLEGAL;
        if (aluop == ALUOP_ADD) begin
            ctl = CTL_ADD;
        end else if ((aluop & ALUOP_SUB) != 2'b00) begin
            ctl = CTL_SUB;
        end else if (aluop == ALUOP_RTYPE) begin
            case (funct)
                FUNCT_ADD, FUNCT_ADDU: ctl = CTL_ADD;
                FUNCT_SUB, FUNCT_SUBU: ctl = CTL_SUB;
                FUNCT_AND:             ctl = CTL_AND;
                FUNCT_OR:              ctl = CTL_OR;
                FUNCT_XOR:             ctl = CTL_XOR;
                FUNCT_NOR:             ctl = CTL_NOR;
                FUNCT_SLT:             ctl = CTL_SLT;
                FUNCT_SLTU:            ctl = CTL_SLTU;
                FUNCT_SLL:             ctl = CTL_SLL;
                FUNCT_SRL:             ctl = CTL_SRL;
                FUNCT_SRA:             ctl = CTL_SRA;
                FUNCT_MULT:            ctl = CTL_MULT;
                FUNCT_MULTU:           ctl = CTL_MULTU;
                FUNCT_MFHI:            ctl = CTL_MFHI;
                FUNCT_MFLO:            ctl = CTL_MFLO;
                default:               ctl = CTL_ILLEGAL;
            endcase
        end
        return ctl;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// EX-stage operation/result bundle between the pipeline and alu_exec_unit.
interface alu_exec_unit_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    // Handshake: an operation transfers on a rising edge where in_valid && in_ready;
    // while in_ready is low the master holds all operation fields stable.
    // out_valid is a one-cycle pulse, never back-pressured; result/zero/ALUCtl hold after it.
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         ALUOp;
    logic [5:0]         FuncCode;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [3:0]         ALUCtl;
    logic               out_valid;
    logic [DATA_W-1:0]  result;
    logic               zero;
    logic               illegal;
    logic               overflow;

    modport master (
        output in_valid, ALUOp, FuncCode, shamt, op_a, op_b,
        input  in_ready, ALUCtl, out_valid, result, zero, illegal, overflow
    );

    modport slave (
        input  in_valid, ALUOp, FuncCode, shamt, op_a, op_b,
        output in_ready, ALUCtl, out_valid, result, zero, illegal, overflow
    );
endinterface

// File: rtl/iter_multiplier.sv
// Radix-2 shift-add multiplier on operand magnitudes; DATA_W iterations after start,
// sign fixed up on the product output for signed mode.
module iter_multiplier #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_signed_mode,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_product
);
    localparam int CNT_W = $clog2(DATA_W);

    logic                r_busy;
    logic [CNT_W-1:0]    r_count;
    logic                r_neg;
    logic [DATA_W-1:0]   r_mcand;
    logic [2*DATA_W-1:0] r_acc;

    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W-1:0]   w_addend;
    logic [DATA_W:0]     w_hi_sum;

    // Negating the most negative value wraps back to itself, which is its correct magnitude.
    assign w_a_mag  = (i_signed_mode && i_a[DATA_W-1]) ? -i_a : i_a;
    assign w_b_mag  = (i_signed_mode && i_b[DATA_W-1]) ? -i_b : i_b;
    assign w_addend = r_acc[0] ? r_mcand : '0;
    assign w_hi_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, w_addend};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_count <= '0;
            r_neg   <= 1'b0;
            r_mcand <= '0;
            r_acc   <= '0;
        end else if (i_start && !r_busy) begin
            r_busy  <= 1'b1;
            r_count <= CNT_W'(DATA_W - 1);
            r_neg   <= i_signed_mode && (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
            r_mcand <= w_a_mag;
            r_acc   <= {{DATA_W{1'b0}}, w_b_mag};
        end else if (r_busy) begin
            r_acc <= {w_hi_sum, r_acc[DATA_W-1:1]};
            if (r_count == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // done marks the cycle whose closing edge performs the final iteration.
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_count == '0);
    assign o_product = r_neg ? -r_acc : r_acc;
endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: ALUOp/funct decode, registered single-cycle datapath, iterative multiply
// with HI/LO. Optional signed-overflow flag on add/sub under ALU_OVERFLOW_TRAP_EN.
module alu_exec_unit
    import alu_ctl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus,
    output logic [1:0]      o_dbg_state,
    output logic            o_dbg_mul_busy
);
    state_t              r_state;
    logic [3:0]          r_alu_ctl;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_illegal;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic [3:0]          w_ctl;
    logic                w_accept;
    logic                w_is_mul;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_res;
    logic                w_mul_busy;
    logic                w_mul_done;
    logic [2*DATA_W-1:0] w_product;

    assign w_ctl    = decode_ctl(bus.ALUOp, bus.FuncCode);
    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_is_mul = (w_ctl == CTL_MULT) || (w_ctl == CTL_MULTU);
    assign w_shamt  = bus.shamt;
    assign w_sum    = bus.op_a + bus.op_b;
    assign w_diff   = bus.op_a - bus.op_b;

    always_comb begin
        w_res = '0;
        case (w_ctl)
            CTL_ADD:  w_res = w_sum;
            CTL_SUB:  w_res = w_diff;
            CTL_AND:  w_res = bus.op_a & bus.op_b;
            CTL_OR:   w_res = bus.op_a | bus.op_b;
            CTL_XOR:  w_res = bus.op_a ^ bus.op_b;
            CTL_NOR:  w_res = ~(bus.op_a | bus.op_b);
            CTL_SLT:  w_res[0] = $signed(bus.op_a) < $signed(bus.op_b);
            CTL_SLTU: w_res[0] = bus.op_a < bus.op_b;
            CTL_SLL:  w_res = bus.op_a << w_shamt;
            CTL_SRL:  w_res = bus.op_a >> w_shamt;
            CTL_SRA:  w_res = $signed(bus.op_a) >>> w_shamt;
            CTL_MFHI: w_res = r_hi;
            CTL_MFLO: w_res = r_lo;
            default:  w_res = '0;
        endcase
    end

    iter_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk           (clk),
        .reset         (reset),
        .i_start       (w_accept && w_is_mul),
        .i_signed_mode (w_ctl == CTL_MULT),
        .i_a           (bus.op_a),
        .i_b           (bus.op_b),
        .o_busy        (w_mul_busy),
        .o_done        (w_mul_done),
        .o_product     (w_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_alu_ctl   <= 4'b0000;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_ctl <= w_ctl;
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_out_valid <= 1'b1;
                            r_illegal   <= (w_ctl == CTL_ILLEGAL);
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_hi        <= w_product[2*DATA_W-1:DATA_W];
                    r_lo        <= w_product[DATA_W-1:0];
                    r_result    <= w_product[DATA_W-1:0];
                    r_zero      <= (w_product[DATA_W-1:0] == '0);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_OVERFLOW_TRAP_EN
    logic w_ovf;
    logic r_overflow;

    // Only trapping R-type add/sub flag; ALUOp-forced add/sub and the unsigned forms never do.
    always_comb begin
        w_ovf = 1'b0;
        if (bus.ALUOp == ALUOP_RTYPE) begin
            if (bus.FuncCode == FUNCT_ADD) begin
                w_ovf = (bus.op_a[DATA_W-1] == bus.op_b[DATA_W-1]) &&
                        (w_sum[DATA_W-1] != bus.op_a[DATA_W-1]);
            end else if (bus.FuncCode == FUNCT_SUB) begin
                w_ovf = (bus.op_a[DATA_W-1] != bus.op_b[DATA_W-1]) &&
                        (w_diff[DATA_W-1] != bus.op_a[DATA_W-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_accept && !w_is_mul && w_ovf;
        end
    end

    assign bus.overflow = r_overflow;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.in_ready    = (r_state == ST_IDLE);
    assign bus.ALUCtl      = r_alu_ctl;
    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.zero        = r_zero;
    assign bus.illegal     = r_illegal;
    assign o_dbg_state     = r_state;
    assign o_dbg_mul_busy  = w_mul_busy;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized bench for alu_exec_unit against a plain-arithmetic reference model.
module tb_alu_exec_unit;
  localparam int DW = 32;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.DATA_W(DW), .SHAMT_W(SW)) bus ();
  logic [1:0] dbg_state;
  logic       dbg_busy;

  alu_exec_unit #(.DATA_W(DW), .SHAMT_W(SW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_mul_busy (dbg_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the ALU's instruction-level meaning, written with ordinary arithmetic.
  task automatic model(input logic [1:0] aluop, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [3:0] ctl, output logic [31:0] res,
                       output logic ill, output logic ovf, output logic mul);
    logic [63:0] p;
    logic [31:0] s;
    logic [31:0] d;
    s = a + b;
    d = a - b;
    ctl = 4'hF; res = '0; ill = 1'b0; ovf = 1'b0; mul = 1'b0;
    if (aluop == 2'b00) begin
      ctl = 4'b0010; res = s;
    end else if (aluop[0]) begin
      ctl = 4'b0110; res = d;
    end else begin
      case (fn)
        6'b100000, 6'b100001: begin
          ctl = 4'b0010; res = s;
          ovf = (fn == 6'b100000) && (a[31] == b[31]) && (s[31] != a[31]);
        end
        6'b100010, 6'b100011: begin
          ctl = 4'b0110; res = d;
          ovf = (fn == 6'b100010) && (a[31] != b[31]) && (d[31] != a[31]);
        end
        6'b100100: begin ctl = 4'b0000; res = a & b; end
        6'b100101: begin ctl = 4'b0001; res = a | b; end
        6'b100110: begin ctl = 4'b0011; res = a ^ b; end
        6'b100111: begin ctl = 4'b1100; res = ~(a | b); end
        6'b101010: begin ctl = 4'b0111; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6'b101011: begin ctl = 4'b0101; res = (a < b) ? 32'd1 : 32'd0; end
        6'b000000: begin ctl = 4'b1000; res = a << sh; end
        6'b000010: begin ctl = 4'b1001; res = a >> sh; end
        6'b000011: begin ctl = 4'b1010; res = 32'($signed(a) >>> sh); end
        6'b011000: begin
          ctl = 4'b1011; mul = 1'b1;
          p = longint'($signed(a)) * longint'($signed(b));
          m_hi = p[63:32]; m_lo = p[31:0]; res = p[31:0];
        end
        6'b011001: begin
          ctl = 4'b0100; mul = 1'b1;
          p = {32'd0, a} * {32'd0, b};
          m_hi = p[63:32]; m_lo = p[31:0]; res = p[31:0];
        end
        6'b010000: begin ctl = 4'b1101; res = m_hi; end
        6'b010010: begin ctl = 4'b1110; res = m_lo; end
        default:   begin ctl = 4'b1111; res = '0; ill = 1'b1; end
      endcase
    end
`ifndef ALU_OVERFLOW_TRAP_EN
    ovf = 1'b0;
`endif
  endtask

  task automatic drive(input logic [1:0] aluop, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.ALUOp = aluop;
    bus.FuncCode = fn;
    bus.shamt = sh;
    bus.op_a = a;
    bus.op_b = b;
  endtask

  task automatic issue(input logic [1:0] aluop, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!bus.in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) check("in_ready_timeout", 64'(k), 64'(0));
    drive(aluop, fn, sh, a, b);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] aluop, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    logic [3:0] e_ctl;
    logic [31:0] e_res;
    logic e_ill, e_ovf, e_mul;
    int cnt, low;
    model(aluop, fn, sh, a, b, e_ctl, e_res, e_ill, e_ovf, e_mul);
    issue(aluop, fn, sh, a, b);
    if (e_mul) begin
      cnt = 0; low = 0;
      while (!bus.out_valid && cnt < 100) begin
        if (!bus.in_ready) low++;
        @(posedge clk); #1;
        cnt++;
      end
      check({tag, "_mul_latency"}, 64'(cnt), 64'(33));
      check({tag, "_ready_low_cycles"}, 64'(low), 64'(33));
      check({tag, "_ready_back"}, 64'(bus.in_ready), 64'(1));
    end
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_result"}, 64'(bus.result), 64'(e_res));
    check({tag, "_alu_ctl"}, 64'(bus.ALUCtl), 64'(e_ctl));
    check({tag, "_zero"}, 64'(bus.zero), 64'(e_res == 32'd0));
    check({tag, "_illegal"}, 64'(bus.illegal), 64'(e_ill));
    check({tag, "_overflow"}, 64'(bus.overflow), 64'(e_ovf));
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 64'(bus.out_valid), 64'(0));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] legal [15];
    logic [1:0] r_aluop;
    logic [5:0] r_fn;
    logic [3:0] e_ctl;
    logic [31:0] e_res1, e_res2;
    logic e_ill, e_ovf, e_mul;
    int seen;
    legal = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
              6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
              6'b000011, 6'b011000, 6'b011001};

    bus.in_valid = 1'b0; bus.ALUOp = 2'b00; bus.FuncCode = '0;
    bus.shamt = '0; bus.op_a = '0; bus.op_b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_alu_ctl", 64'(bus.ALUCtl), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_zero", 64'(bus.zero), 64'(0));
    check("rst_illegal", 64'(bus.illegal), 64'(0));
    check("rst_overflow", 64'(bus.overflow), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));

    // Load non-zero HI/LO, then abort a multiply with reset and confirm HI was cleared.
    run_op("multu_pre", 2'b10, 6'b011001, 5'd0, 32'hFFFF_FFFD, 32'd7);
    issue(2'b10, 6'b011000, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    check("midrst_alu_ctl", 64'(bus.ALUCtl), 64'(0));
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("midrst_no_out_valid", 64'(seen), 64'(0));
    run_op("mfhi_after_rst", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
    check("mfhi_after_rst_const", 64'(bus.result), 64'(0));
    run_op("mflo_after_rst", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0);

    run_op("slt", 2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("slt_const", 64'(bus.result), 64'(1));
    check("slt_ctl_const", 64'(bus.ALUCtl), 64'(4'b0111));
    run_op("sltu", 2'b10, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("sltu_zero_const", 64'(bus.zero), 64'(1));

    run_op("sra", 2'b10, 6'b000011, 5'd4, 32'h8000_0000, 32'd0);
    check("sra_const", 64'(bus.result), 64'(32'hF800_0000));
    run_op("sra31", 2'b10, 6'b000011, 5'd31, 32'h8000_0000, 32'd0);
    run_op("sll31", 2'b10, 6'b000000, 5'd31, 32'h0000_0003, 32'd0);

    run_op("mult", 2'b10, 6'b011000, 5'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_lo_const", 64'(bus.result), 64'(32'hFFFF_FFEB));
    run_op("mfhi_mult", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
    check("mfhi_mult_const", 64'(bus.result), 64'(32'hFFFF_FFFF));
    run_op("multu", 2'b10, 6'b011001, 5'd0, 32'hFFFF_FFFD, 32'd7);
    run_op("mfhi_multu", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
    check("mfhi_multu_const", 64'(bus.result), 64'(32'h0000_0006));
    run_op("mflo_multu", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0);
    check("mflo_multu_const", 64'(bus.result), 64'(32'hFFFF_FFEB));
    run_op("mult_minneg", 2'b10, 6'b011000, 5'd0, 32'h8000_0000, 32'h8000_0000);

    run_op("illegal", 2'b10, 6'b111111, 5'd0, 32'h1234_5678, 32'h1);
    check("illegal_ctl_const", 64'(bus.ALUCtl), 64'(4'hF));
    check("illegal_flag_const", 64'(bus.illegal), 64'(0));
    run_op("aluop11_sub", 2'b11, 6'b111111, 5'd0, 32'd5, 32'd9);

    // Back-to-back add then sub on consecutive edges.
    model(2'b10, 6'b100001, 5'd0, 32'd100, 32'd23, e_ctl, e_res1, e_ill, e_ovf, e_mul);
    model(2'b10, 6'b100011, 5'd0, 32'd100, 32'd23, e_ctl, e_res2, e_ill, e_ovf, e_mul);
    drive(2'b10, 6'b100001, 5'd0, 32'd100, 32'd23);
    @(posedge clk); #1;
    drive(2'b10, 6'b100011, 5'd0, 32'd100, 32'd23);
    check("b2b_add_valid", 64'(bus.out_valid), 64'(1));
    check("b2b_add_result", 64'(bus.result), 64'(e_res1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_sub_valid", 64'(bus.out_valid), 64'(1));
    check("b2b_sub_result", 64'(bus.result), 64'(e_res2));
    @(posedge clk); #1;
    check("b2b_pulse_end", 64'(bus.out_valid), 64'(0));

    run_op("add_ovf", 2'b10, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf_result_const", 64'(bus.result), 64'(32'h8000_0000));
`ifdef ALU_OVERFLOW_TRAP_EN
    check("add_ovf_flag_const", 64'(bus.overflow), 64'(0));
`endif
    run_op("addu_noovf", 2'b10, 6'b100001, 5'd0, 32'h7FFF_FFFF, 32'd1);
    run_op("sub_ovf", 2'b10, 6'b100010, 5'd0, 32'h8000_0000, 32'd1);
    run_op("aluop00_noovf", 2'b00, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: r_aluop = 2'b00;
        1: r_aluop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
        default: r_aluop = 2'b10;
      endcase
      case ($urandom_range(0, 9))
        0: r_fn = 6'($urandom_range(0, 63));
        1: r_fn = ($urandom_range(0, 1) == 0) ? 6'b010000 : 6'b010010;
        default: r_fn = legal[$urandom_range(0, 14)];
      endcase
      run_op("rand", r_aluop, r_fn, 5'($urandom_range(0, 31)), rnd_operand(), rnd_operand());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
